// File: rtl/mult_datapath.sv
// -----------------------------------------------------------------------------
// mult_datapath
//   Register datapath for a shift-and-add signed multiplier. Holds the
//   sign-extension bit X, the accumulator A and the multiplier B. A, B and X
//   shift right together as one arithmetic shift X:A:B. A saturating shift
//   counter raises prod_valid_o once WIDTH shifts have completed since the
//   last clear or load. One action takes effect per cycle, in priority order:
//   clear > load > subtract > add > shift > hold.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   s_i            switch operand (multiplicand / load value), two's complement
//   clr_xa_i       clear X, A and the shift count
//   ld_a_i         load A from s_i
//   ld_b_i         load B from s_i
//   add_en_i       {X,A} <= A + S (signed, WIDTH+1 bits)
//   sub_en_i       {X,A} <= A - S (signed, WIDTH+1 bits)
//   shift_en_i     arithmetic right shift of X:A:B
//   aval_o         A register
//   bval_o         B register
//   x_o            sign-extension flip-flop
//   m_o            B[0], fed back to the multiplier controller
//   prod_valid_o   WIDTH shifts completed since the last clear/load
// -----------------------------------------------------------------------------
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_i,
  input  logic             clr_xa_i,
  input  logic             ld_a_i,
  input  logic             ld_b_i,
  input  logic             add_en_i,
  input  logic             sub_en_i,
  input  logic             shift_en_i,
  output logic [WIDTH-1:0] aval_o,
  output logic [WIDTH-1:0] bval_o,
  output logic             x_o,
  output logic             m_o,
  output logic             prod_valid_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pv_q, pv_d;

  // Both operands are sign-extended to WIDTH+1 bits, so the result can never
  // overflow; its top bit is the true sign and becomes X.
  logic [WIDTH:0] a_ext, s_ext, sum, diff;

  assign a_ext = {a_q[WIDTH-1], a_q};
  assign s_ext = {s_i[WIDTH-1], s_i};
  assign sum   = a_ext + s_ext;
  assign diff  = a_ext - s_ext;

  always_comb begin
    // NOTE: every signal gets a hold value first so no path can infer a latch.
    x_d   = x_q;
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    pv_d  = pv_q;

    if (clr_xa_i) begin
      x_d   = 1'b0;
      a_d   = '0;
      cnt_d = '0;
      pv_d  = 1'b0;
    end else if (ld_a_i || ld_b_i) begin
      // Both loads may be honoured in the same cycle.
      if (ld_a_i) a_d = s_i;
      if (ld_b_i) b_d = s_i;
      cnt_d = '0;
      pv_d  = 1'b0;
    end else if (sub_en_i) begin
      x_d = diff[WIDTH];
      a_d = diff[WIDTH-1:0];
    end else if (add_en_i) begin
      x_d = sum[WIDTH];
      a_d = sum[WIDTH-1:0];
    end else if (shift_en_i) begin
      // X replicates into A's MSB, A's LSB moves into B; X itself holds.
      a_d   = {x_q, a_q[WIDTH-1:1]};
      b_d   = {a_q[0], b_q[WIDTH-1:1]};
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      pv_d  = pv_q | (cnt_d == CNT_MAX);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      pv_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      pv_q  <= pv_d;
    end
  end

  // Outputs come straight from registers; no input reaches an output.
  assign aval_o       = a_q;
  assign bval_o       = b_q;
  assign x_o          = x_q;
  assign m_o          = b_q[0];
  assign prod_valid_o = pv_q;

endmodule

// File: doc/mult_datapath.md
MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 Parameter: WIDTH, default 8, operand width for A, B and S; the block SHALL be verified at WIDTH=8.
REQ-002 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  reset SHALL be asynchronous and active-low (0 = reset asserted).
REQ-004 S  input  WIDTH  switch operand (multiplicand / load value), two's complement.
REQ-005 Clr_XA  input  1  clear X and A; clear shift count.
REQ-006 Ld_A  input  1  load A from S.
REQ-007 Ld_B  input  1  load B from S (multiplier).
REQ-008 Add_En  input  1  {X,A} <= A + S, signed.
REQ-009 Sub_En  input  1  {X,A} <= A - S, signed.
REQ-010 Shift_En  input  1  arithmetic right shift of X:A:B.
REQ-011 Aval  output  WIDTH  A register.
REQ-012 Bval  output  WIDTH  B register.
REQ-013 X  output  1  sign-extension flip-flop.
REQ-014 M  output  1  B[0], fed back to the multiplier controller.
REQ-015 Prod_Valid  output  1  high once WIDTH shifts have completed since the last clear/load.

Function
REQ-016 State SHALL be X, A[WIDTH-1:0], B[WIDTH-1:0], a shift counter Cnt of ceil(log2(WIDTH+1)) bits, and Prod_Valid.
REQ-017 Each cycle, exactly one action SHALL take effect, chosen in priority order: Clr_XA > (Ld_A/Ld_B) > Sub_En > Add_En > Shift_En > hold.
REQ-018 Clr_XA: X<=0, A<=0, Cnt<=0, Prod_Valid<=0; B unchanged.
REQ-019 Ld_A and Ld_B SHALL be honoured together when both are high: A<=S if Ld_A, B<=S if Ld_B; Cnt<=0, Prod_Valid<=0; X unchanged.
REQ-020 Add_En: a (WIDTH+1)-bit sum of sign-extended A and sign-extended S SHALL be formed; X<=sum[WIDTH], A<=sum[WIDTH-1:0]; B and Cnt unchanged.
REQ-021 Sub_En: same as Add_En, with the sign-extended difference A minus S in WIDTH+1 bits.
REQ-022 Neither Add_En nor Sub_En SHALL flag overflow; wrap is confined to WIDTH+1 bits by construction.
REQ-023 Shift_En: X unchanged, A<={X, A[WIDTH-1:1]}, B<={A[0], B[WIDTH-1:1]}.
REQ-023a Shift_En: Cnt<=Cnt+1, saturating at WIDTH.
REQ-024 Prod_Valid SHALL go high on the clock edge where Cnt becomes WIDTH, and stay high until Clr_XA, Ld_A, Ld_B or Reset.
REQ-025 Shifts after saturation SHALL still shift the data; Prod_Valid stays 1.
REQ-026 Outputs SHALL be driven combinationally from registers only, with no path from any input to any output.
REQ-026a Outputs: M=B[0], Aval=A, Bval=B, X=X.
REQ-027 With no control asserted, all state SHALL hold.
REQ-028 Every action SHALL be visible on the outputs one cycle after the enabling edge (latency 1).

Reset
REQ-029 While Reset=0, the block SHALL immediately force X=0, A=0, B=0, Cnt=0, Prod_Valid=0 (so M=0), independent of Clk.
REQ-030 Reset asserted mid-multiply SHALL abort the multiply; on release, the block SHALL ignore any controls already in flight until the next Clk edge.
REQ-031 Release of Reset SHALL be synchronous to Clk in the system; the block adds no synchronizer.

Verification
REQ-032 Ld_B with S=0xFD, then Clr_XA, then S=0x07 with the 8-step add/shift sequence (add when M=1, sub on step 8), ending with the final shift -> A=0xFF, B=0xEB (-21), Prod_Valid=1.
REQ-033 B=0x80, S=0x80, full sequence with final Sub -> A=0x40, B=0x00 (+16384), X=0.
REQ-034 A=0x7F, S=0x01, Add_En -> X=0, A=0x80; then A=0x00, S=0x80, Sub_En -> X=0, A=0x80.
REQ-035 Clr_XA+Add_En+Shift_En in the same cycle -> only clear applies: X=0, A=0, B unchanged.
REQ-035a Ld_A+Ld_B in the same cycle, S=0x5A -> A=B=0x5A.
REQ-036 Reset pulled low between two clock edges, mid-sequence -> all outputs 0 immediately, before the next edge.
REQ-036a After the Reset pulse of REQ-036, held Shift_En -> shifting resumes from zero.
REQ-037 Nine consecutive Shift_En after a load -> Prod_Valid rises after the 8th shift and stays 1 after the 9th; data keeps shifting.
